// File: rtl/lfsr_burst_arbiter.sv
// Round-robin arbiter that shares one Galois LFSR between two requesters.
// A granted requester receives a burst of pseudo-random words over a valid/ready handshake.
module lfsr_burst_arbiter #(
    parameter int unsigned       WIDTH    = 8,
    parameter logic [WIDTH-1:0]  POLY     = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0]  SEED_RST = WIDTH'(8'hA5),
    parameter int unsigned       LEN_W    = 4
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             done,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_seed,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_lfsr;
    logic [LEN_W-1:0] r_cnt;
    logic [1:0]       r_gnt;
    logic             r_last;
    logic             r_win;

    logic [WIDTH-1:0] w_step;
    logic             w_win;
    logic [LEN_W-1:0] w_len;
    logic             w_hs;

    // Next LFSR value; also the word presented on dout.
    always_comb begin
        w_step = {r_lfsr[WIDTH-2:0], 1'b0} ^ (r_lfsr[WIDTH-1] ? POLY : '0);
    end

    // With both requesting, the one not served last wins.
    always_comb begin
        w_win = 1'b0;
        if (req == 2'b11) begin
            w_win = ~r_last;
        end else begin
            w_win = req[1];
        end
        w_len = w_win ? len1 : len0;
        w_hs  = (r_state == ST_BURST) && dout_rdy;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= ST_IDLE;
            r_lfsr  <= SEED_RST;
            r_cnt   <= '0;
            r_gnt   <= 2'b00;
            r_last  <= 1'b1;
            r_win   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_we) begin
                        r_lfsr <= (cfg_seed == '0) ? WIDTH'(1) : cfg_seed;
                    end else if (req != 2'b00) begin
                        r_win   <= w_win;
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_cnt   <= w_len - LEN_W'(1);
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_hs) begin
                        r_lfsr <= w_step;
                        if (r_cnt == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt - LEN_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_last  <= r_win;
                    r_gnt   <= 2'b00;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

    assign dout     = w_step;
    assign gnt      = r_gnt;
    assign dout_vld = (r_state == ST_BURST);
    assign done     = (r_state == ST_DONE);
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// Self-checking bench for lfsr_burst_arbiter: directed scenarios plus randomized bursts
// compared against a transaction-level model of the word sequence and round-robin order.
module tb_lfsr_burst_arbiter;

    logic       clk;
    logic       res_n;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic       done;
    logic       cfg_we;
    logic [7:0] cfg_seed;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: the next value the LFSR will step from, and the last-served requester.
    logic [7:0] m_lfsr;
    int         m_last;
    int         g_tab_idx;
    logic [7:0] tab [10];

    lfsr_burst_arbiter dut (
        .clk      (clk),
        .res_n    (res_n),
        .req      (req),
        .len0     (len0),
        .len1     (len1),
        .gnt      (gnt),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .done     (done),
        .cfg_we   (cfg_we),
        .cfg_seed (cfg_seed),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] s);
        logic [8:0] t;
        t = {s, 1'b0};
        if (t[8]) t[7:0] = t[7:0] ^ 8'h1D;
        return t[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Runs one burst starting from IDLE (called at posedge+1); returns at posedge+1 in IDLE.
    task automatic do_burst(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                            input int rdy_pct, input bit hold, input bit disturb);
        int         win;
        int         n;
        int         k;
        int         stall;
        int         cyc;
        bit         rdy;
        logic [1:0] oh;
        logic [3:0] lw;
        win = (r == 2'b11) ? (1 - m_last) : (r[1] ? 1 : 0);
        lw  = (win == 1) ? l1 : l0;
        n   = (lw == 4'd0) ? 16 : int'(lw);
        oh  = (win == 1) ? 2'b10 : 2'b01;
        req = r; len0 = l0; len1 = l1; dout_rdy = 1'b0;
        @(posedge clk); #1;
        chk("gnt_start", 32'(gnt), 32'(oh));
        chk("vld_start", 32'(dout_vld), 32'd1);
        chk("busy_start", 32'(busy), 32'd1);
        k = 0; stall = 0; cyc = 0;
        while (k < n && cyc < 400) begin
            chk("dout", 32'(dout), 32'(step(m_lfsr)));
            chk("vld", 32'(dout_vld), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            chk("gnt_hold", 32'(gnt), 32'(oh));
            rdy   = (stall >= 3) || ($urandom_range(99) < rdy_pct);
            stall = rdy ? 0 : stall + 1;
            if (rdy && g_tab_idx >= 0 && g_tab_idx < 10) begin
                chk("tab", 32'(dout), 32'(tab[g_tab_idx]));
                g_tab_idx++;
            end
            dout_rdy = rdy;
            if (disturb) begin
                cfg_we   = ($urandom_range(2) == 0);
                cfg_seed = 8'($urandom);
                len0     = 4'($urandom);
                len1     = 4'($urandom);
                if (k > 0) req = 2'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
            if (rdy) begin
                m_lfsr = step(m_lfsr);
                k++;
            end
        end
        cfg_we = 1'b0; dout_rdy = 1'b0;
        if (k < n) chk("burst_timeout", 32'(k), 32'(n));
        chk("done", 32'(done), 32'd1);
        chk("vld_done", 32'(dout_vld), 32'd0);
        chk("gnt_done", 32'(gnt), 32'(oh));
        chk("busy_done", 32'(busy), 32'd1);
        if (!hold) req = 2'b00;
        @(posedge clk); #1;
        chk("done_clr", 32'(done), 32'd0);
        chk("gnt_clr", 32'(gnt), 32'd0);
        chk("busy_clr", 32'(busy), 32'd0);
        m_last = win;
    endtask

    // Seed write in IDLE with a request pending: arbitration must not happen that cycle.
    task automatic load_seed(input logic [7:0] s);
        cfg_we = 1'b1; cfg_seed = s; req = 2'b01;
        @(posedge clk); #1;
        cfg_we = 1'b0; req = 2'b00;
        m_lfsr = (s == 8'h00) ? 8'h01 : s;
        chk("seed_busy", 32'(busy), 32'd0);
        chk("seed_gnt", 32'(gnt), 32'd0);
        chk("seed_dout", 32'(dout), 32'(step(m_lfsr)));
        if (s == 8'h00) chk("seed_zero", 32'(dout), 32'h02);
    endtask

    initial begin
        tab[0] = 8'h57; tab[1] = 8'hAE; tab[2] = 8'h41; tab[3] = 8'h82; tab[4] = 8'h19;
        tab[5] = 8'h32; tab[6] = 8'h64; tab[7] = 8'hC8; tab[8] = 8'h8D; tab[9] = 8'h07;
        g_tab_idx = -1;
        res_n = 1'b0; req = 2'b00; len0 = 4'd0; len1 = 4'd0;
        dout_rdy = 1'b0; cfg_we = 1'b0; cfg_seed = 8'h00;
        m_lfsr = 8'hA5; m_last = 1;
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_vld", 32'(dout_vld), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", 32'(dout), 32'h57);
        #10 res_n = 1'b1;
        @(posedge clk); #1;

        // Single requester, fixed words from reset seed.
        g_tab_idx = 0;
        do_burst(2'b01, 4'd4, 4'd4, 100, 1'b0, 1'b0);
        // Both requesting with req held: requester 1 is next after 0.
        do_burst(2'b11, 4'd2, 4'd2, 100, 1'b1, 1'b0);
        do_burst(2'b11, 4'd2, 4'd2, 100, 1'b1, 1'b0);
        do_burst(2'b11, 4'd2, 4'd2, 100, 1'b0, 1'b0);
        g_tab_idx = -1;
        // Stalls during a burst, then a full 16-word burst.
        do_burst(2'b01, 4'd5, 4'd1, 40, 1'b0, 1'b0);
        do_burst(2'b01, 4'd0, 4'd3, 100, 1'b0, 1'b0);
        do_burst(2'b10, 4'd1, 4'd0, 70, 1'b0, 1'b0);
        // Zero seed maps to 1; cfg_we and req changes during a burst are ignored.
        load_seed(8'h00);
        do_burst(2'b01, 4'd3, 4'd3, 100, 1'b0, 1'b1);
        load_seed(8'h3C);
        do_burst(2'b10, 4'd6, 4'd2, 60, 1'b0, 1'b1);

        // Randomized bursts.
        for (int i = 0; i < 30; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            if ($urandom_range(4) == 0) load_seed(8'($urandom));
            do_burst(r, 4'($urandom), 4'($urandom), $urandom_range(30, 100),
                     1'($urandom), 1'($urandom));
            req = 2'b00;
        end

        // Reset mid-burst aborts at once and restarts the sequence.
        req = 2'b01; len0 = 4'd8; dout_rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        res_n = 1'b0; req = 2'b00; dout_rdy = 1'b0;
        #2;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_vld", 32'(dout_vld), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_dout", 32'(dout), 32'h57);
        m_lfsr = 8'hA5; m_last = 1;
        @(posedge clk); #3;
        res_n = 1'b1;
        @(posedge clk); #1;
        g_tab_idx = 0;
        do_burst(2'b11, 4'd3, 4'd3, 100, 1'b0, 1'b0);
        g_tab_idx = -1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
